// File: rtl/mult4_pkg.sv
// Shared definitions for the 4x4 shift-and-add multiplier.
//   N          operand width (fixed to match adder4)
//   ITER_LAST  count value on the final add/shift iteration
//   mult_state_t  controller states
package mult4_pkg;

    localparam int N = 4;
    localparam logic [1:0] ITER_LAST = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/shift_add_mult4_if.sv
// Valid/ready bundle for the shift-and-add multiplier.
//   in_valid/in_ready/a/b        operand handshake (upstream -> multiplier)
//   out_valid/out_ready/product  result handshake (multiplier -> downstream)
// master: the side that supplies operands and consumes products.
// slave:  the multiplier itself.
interface shift_add_mult4_if;
    import mult4_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   product;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );

endinterface

// File: rtl/adder4.sv
// 4-bit ripple-carry adder used for one partial-product add per cycle.
//   cin   carry in
//   x, y  4-bit addends
//   s     4-bit sum
//   cout  carry out
module adder4
    import mult4_pkg::*;
(
    input  logic         cin,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] s,
    output logic         cout
);

    // Carries kept as separate elements so each bit's carry is its own net.
    logic carry [0:N];

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign s[gi]        = x[gi] ^ y[gi] ^ carry[gi];
            assign carry[gi+1]  = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
        end
    endgenerate

    assign cout = carry[N];

endmodule

// File: rtl/shift_add_mult4.sv
// Sequential 4x4 unsigned shift-and-add multiplier, 8-bit registered product.
// One adder4 add per cycle, four iterations per multiply.
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  slave side of shift_add_mult4_if (operand and product handshakes)
module shift_add_mult4
    import mult4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    shift_add_mult4_if.slave  bus
);

    mult_state_t      state_reg, state_next;
    logic [N-1:0]     acc_reg, acc_next;
    logic [N-1:0]     mcand_reg, mcand_next;
    logic [N-1:0]     q_reg, q_next;
    logic [1:0]       count_reg, count_next;
    logic [2*N-1:0]   product_reg, product_next;

    logic [N-1:0]     addend;
    logic [N-1:0]     sum;
    logic             carry;

    // Add the multiplicand only when the current multiplier LSB is set.
    assign addend = q_reg[0] ? mcand_reg : '0;

    adder4 u_adder4 (
        .cin  (1'b0),
        .x    (acc_reg),
        .y    (addend),
        .s    (sum),
        .cout (carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            q_reg       <= '0;
            count_reg   <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            mcand_reg   <= mcand_next;
            q_reg       <= q_next;
            count_reg   <= count_next;
            product_reg <= product_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        mcand_next   = mcand_reg;
        q_next       = q_reg;
        count_next   = count_reg;
        product_next = product_reg;

        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_next = bus.a;
                    q_next     = bus.b;
                    acc_next   = '0;
                    count_next = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                // {acc,q} shifts right by one with the adder carry entering
                // at the top, so the carry is never lost.
                acc_next   = {carry, sum[N-1:1]};
                q_next     = {sum[0], q_reg[N-1:1]};
                count_next = count_reg + 2'd1;
                if (count_reg == ITER_LAST) begin
                    product_next = {carry, sum[N-1:1], sum[0], q_reg[N-1:1]};
                    state_next   = DONE;
                end
            end
            DONE: begin
                // Only the output handshake is serviced here; a pending
                // operand waits until IDLE.
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.product   = product_reg;

endmodule
